frame_guard: RTL and testbench
==============================

FRAME_GUARD -- requirements
Module: frame_guard

Interface
REQ-001 Parameter TIMEOUT, default 32'd2981200: clk cycles without a good frame before the timeout fault.
REQ-002 Parameter FRAME_W, default 240: SPI frame width in bits.
REQ-003 Parameter MSGID, default 32'h74697277: required host header.
REQ-004 Parameter NRECOVER, default 2: consecutive good frames required to leave FAULT.
REQ-005 The block has one clock; reset is asynchronous and active-low.
REQ-006 Port clk, in, 1: system clock (PLL sysclk).
REQ-007 Port rst_n, in, 1: asynchronous active-low reset.
REQ-008 Port sync, in, 1: frame-complete strobe from the spi block, asynchronous to clk.
REQ-009 Port rx_data, in, FRAME_W: received frame; header occupies bits [FRAME_W-1:FRAME_W-32], transmitted as little-endian bytes.
REQ-010 Port estop_in, in, 1: external emergency stop, active high, asynchronous.
REQ-011 Port payload, out, FRAME_W-32: committed copy of rx_data[FRAME_W-33:0].
REQ-012 Port run_en, out, 1: permission for stepdir/bitout consumers to act on payload.
REQ-013 Port error, out, 1: equals ~run_en.
REQ-014 Port state, out, 2: 0=IDLE, 1=RUN, 2=FAULT.
REQ-015 Port header_tx, out, 32: 32'h65737470 ("estp") while estop is active, otherwise 32'h64617461 ("data").
REQ-016 Port frame_cnt, out, 16: count of good frames.
REQ-017 Port bad_cnt, out, 8: count of bad-header frames.

Function
REQ-018 sync and estop_in are each registered through a 3-flop shift chain; an edge is detected when chain bits [2:1]==2'b01.
REQ-019 Header value = {rx_data[FRAME_W-25:FRAME_W-32], rx_data[FRAME_W-17:FRAME_W-24], rx_data[FRAME_W-9:FRAME_W-16], rx_data[FRAME_W-1:FRAME_W-8]}.
REQ-020 Good frame: sync edge with header==MSGID. Bad frame: sync edge with any other header.
REQ-021 On a good frame, payload is loaded at the next clk edge, all bits in the same cycle; payload never updates partially and never updates on a bad frame.
REQ-022 Latency: sync rising at the input -> payload updated on the 4th clk edge.
REQ-023 frame_cnt increments on each good frame and wraps 16'hFFFF->0; bad_cnt increments on each bad frame and saturates at 8'hFF.
REQ-024 The timeout counter clears on a good frame, otherwise increments while below TIMEOUT; timeout=1 while counter==TIMEOUT.
REQ-025 A good frame and terminal count in the same cycle: the frame wins, counter clears, and no timeout is raised.
REQ-026 estop active = synchronized estop_in high; it overrides every other FSM condition.
REQ-027 IDLE->RUN on a good frame with estop inactive; IDLE ignores timeout.
REQ-028 RUN->FAULT on timeout or estop active.
REQ-029 FAULT keeps a consecutive-good counter: +1 per good frame, cleared by a bad frame, timeout or estop. FAULT->RUN when the counter reaches NRECOVER with estop inactive; the counter clears on exit.
REQ-030 IDLE->FAULT on estop active.
REQ-031 run_en=1 only in RUN; it changes in the same clk edge as the state register.
REQ-032 header_tx is registered, with 1 clk latency after the synchronized estop.

Reset
REQ-033 With rst_n low, asynchronously: state=IDLE, run_en=0, error=1, payload=0, frame_cnt=0, bad_cnt=0, timeout counter=0, consecutive-good counter=0, sync/estop chains=0, header_tx=32'h64617461.
REQ-034 Reset asserted mid-frame or in FAULT returns all values to REQ-033; the first good frame after release follows REQ-027.

Verification (TIMEOUT=100, NRECOVER=2, FRAME_W=240)
REQ-035 After reset, a good frame with payload 208'h1234 -> payload=208'h1234 on the 4th edge, state=RUN, run_en=1, frame_cnt=1.
REQ-036 In RUN, a frame with header 0xDEADBEEF -> payload unchanged, bad_cnt=1, state stays RUN.
REQ-037 In RUN, no sync for 101 cycles -> state=FAULT, run_en=0, error=1. Then a good, bad, good, good frame sequence -> RUN only after the final good frame.
REQ-038 estop_in raised in RUN -> FAULT within 4 edges, header_tx=32'h65737470. Good frames while estop is held -> state stays FAULT.
REQ-039 A good-frame edge coincides with timeout counter==100 -> no FAULT, counter=0. 65536 good frames -> frame_cnt wraps to 0. 300 bad frames -> bad_cnt=255.
REQ-040 rst_n pulled low for 1 cycle while in RUN -> all REQ-033 values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/frame_guard.sv
// frame_guard: validates SPI host frames, commits payload atomically and gates run_en via an IDLE/RUN/FAULT watchdog
module frame_guard #(
    parameter logic [31:0] TIMEOUT  = 32'd2981200,
    parameter int unsigned FRAME_W  = 240,
    parameter logic [31:0] MSGID    = 32'h74697277,
    parameter int unsigned NRECOVER = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sync,
    input  logic [FRAME_W-1:0]   rx_data,
    input  logic                 estop_in,
    output logic [FRAME_W-33:0]  payload,
    output logic                 run_en,
    output logic                 error,
    output logic [1:0]           state,
    output logic [31:0]          header_tx,
    output logic [15:0]          frame_cnt,
    output logic [7:0]           bad_cnt
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FAULT = 2'd2} state_t;
    localparam logic [31:0] HDR_ESTP = 32'h65737470;
    localparam logic [31:0] HDR_DATA = 32'h64617461;

    logic [2:0]          sync_q, sync_d, estop_q, estop_d;
    logic                good_q, good_d, bad_q, bad_d;
    logic [FRAME_W-33:0] payload_q, payload_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic [7:0]          bad_cnt_q, bad_cnt_d;
    logic [31:0]         tmo_q, tmo_d;
    logic [7:0]          ok_q, ok_d;
    state_t              state_q, state_d;
    logic                run_q, run_d;
    logic [31:0]         hdr_tx_q, hdr_tx_d;
    logic [31:0]         hdr;
    logic                sync_edge, estop, timeout;

    always_comb begin
        hdr         = {rx_data[FRAME_W-25:FRAME_W-32], rx_data[FRAME_W-17:FRAME_W-24],
                       rx_data[FRAME_W-9:FRAME_W-16], rx_data[FRAME_W-1:FRAME_W-8]};
        sync_edge   = sync_q[2:1] == 2'b01;
        estop       = estop_q[2];
        // a frame landing on the terminal count beats the timeout
        timeout     = (tmo_q == TIMEOUT) && !good_q;
        sync_d      = {sync_q[1:0], sync};
        estop_d     = {estop_q[1:0], estop_in};
        good_d      = sync_edge && (hdr == MSGID);
        bad_d       = sync_edge && (hdr != MSGID);
        payload_d   = good_q ? rx_data[FRAME_W-33:0] : payload_q;
        frame_cnt_d = frame_cnt_q + 16'(good_q);
        bad_cnt_d   = (bad_q && bad_cnt_q != 8'hFF) ? bad_cnt_q + 8'd1 : bad_cnt_q;
        tmo_d       = good_q ? 32'd0 : (tmo_q < TIMEOUT ? tmo_q + 32'd1 : tmo_q);
        hdr_tx_d    = estop ? HDR_ESTP : HDR_DATA;
        state_d     = state_q;
        ok_d        = ok_q;
        if (estop) begin
            state_d = FAULT;
            ok_d    = 8'd0;
        end else if (state_q == IDLE) begin
            state_d = good_q ? RUN : IDLE;
        end else if (state_q == RUN) begin
            state_d = timeout ? FAULT : RUN;
        end else begin
            ok_d = (bad_q || timeout) ? 8'd0 : ok_q + 8'(good_q);
            if (good_q && (32'(ok_q) + 32'd1 >= NRECOVER)) begin
                state_d = RUN;
                ok_d    = 8'd0;
            end
        end
        run_d = state_d == RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 3'd0;
            estop_q     <= 3'd0;
            good_q      <= 1'b0;
            bad_q       <= 1'b0;
            payload_q   <= '0;
            frame_cnt_q <= 16'd0;
            bad_cnt_q   <= 8'd0;
            tmo_q       <= 32'd0;
            ok_q        <= 8'd0;
            state_q     <= IDLE;
            run_q       <= 1'b0;
            hdr_tx_q    <= HDR_DATA;
        end else begin
            sync_q      <= sync_d;
            estop_q     <= estop_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            payload_q   <= payload_d;
            frame_cnt_q <= frame_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            tmo_q       <= tmo_d;
            ok_q        <= ok_d;
            state_q     <= state_d;
            run_q       <= run_d;
            hdr_tx_q    <= hdr_tx_d;
        end
    end

    assign payload   = payload_q;
    assign run_en    = run_q;
    assign error     = ~run_q;
    assign state     = state_q;
    assign header_tx = hdr_tx_q;
    assign frame_cnt = frame_cnt_q;
    assign bad_cnt   = bad_cnt_q;
endmodule

// File: tb/tb_frame_guard.sv
// tb_frame_guard: directed and randomized frame sequences checked against a frame-level reference model
module tb_frame_guard;
    localparam int FW = 240;
    localparam logic [31:0] MSG  = 32'h74697277;
    localparam logic [31:0] ESTP = 32'h65737470;
    localparam logic [31:0] DATA = 32'h64617461;

    logic           clk = 1'b0, rst_n = 1'b0, sync = 1'b0, estop_in = 1'b0;
    logic [FW-1:0]  rx_data = '0;
    logic [FW-33:0] payload;
    logic           run_en, error;
    logic [1:0]     state;
    logic [31:0]    header_tx;
    logic [15:0]    frame_cnt;
    logic [7:0]     bad_cnt;

    int checks = 0, errors = 0;
    logic [FW-33:0] m_payload;
    int m_frames, m_bad, m_state, m_ok;
    bit m_estop;

    frame_guard #(.TIMEOUT(32'd100), .FRAME_W(FW), .MSGID(MSG), .NRECOVER(2)) dut (
        .clk(clk), .rst_n(rst_n), .sync(sync), .rx_data(rx_data), .estop_in(estop_in),
        .payload(payload), .run_en(run_en), .error(error), .state(state),
        .header_tx(header_tx), .frame_cnt(frame_cnt), .bad_cnt(bad_cnt)
    );

    always #5 clk = ~clk;

    // host sends the header as little-endian bytes
    function automatic logic [31:0] wire_hdr(input logic [31:0] h);
        return {h[7:0], h[15:8], h[23:16], h[31:24]};
    endfunction

    function automatic logic [FW-33:0] rnd_pl();
        logic [223:0] t = '0;
        for (int i = 0; i < 7; i++) t = {t[191:0], 32'($urandom)};
        return t[FW-33:0];
    endfunction

    function automatic logic [31:0] rnd_bad();
        logic [31:0] h = 32'($urandom);
        return (h == MSG) ? ~h : h;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_payload = '0; m_frames = 0; m_bad = 0; m_state = 0; m_ok = 0; m_estop = 0;
    endtask

    task automatic chk_model(input bit full);
        chk("payload", 256'(payload), 256'(m_payload));
        chk("frame_cnt", 256'(frame_cnt), 256'(m_frames));
        chk("bad_cnt", 256'(bad_cnt), 256'(m_bad));
        if (full) begin
            chk("state", 256'(state), 256'(m_state));
            chk("run_en", 256'(run_en), 256'(m_state == 1));
            chk("error", 256'(error), 256'(m_state != 1));
        end
    endtask

    task automatic chk_reset();
        chk("rst_state", 256'(state), 256'(0));
        chk("rst_run_en", 256'(run_en), 256'(0));
        chk("rst_error", 256'(error), 256'(1));
        chk("rst_payload", 256'(payload), 256'(0));
        chk("rst_frame_cnt", 256'(frame_cnt), 256'(0));
        chk("rst_bad_cnt", 256'(bad_cnt), 256'(0));
        chk("rst_header_tx", 256'(header_tx), 256'(DATA));
    endtask

    // one sync pulse; effects are visible after the 4th rising edge
    task automatic frame(input logic [31:0] hdr, input logic [FW-33:0] pl, input bit full);
        @(negedge clk);
        rx_data = {wire_hdr(hdr), pl};
        sync = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sync = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("payload_edge3", 256'(payload), 256'(m_payload));
        @(posedge clk);
        #1;
        if (hdr == MSG) begin
            m_payload = pl;
            m_frames  = (m_frames + 1) % 65536;
            if (m_estop) begin
                m_state = 2; m_ok = 0;
            end else if (m_state == 0) begin
                m_state = 1;
            end else if (m_state == 2) begin
                m_ok++;
                if (m_ok >= 2) begin m_state = 1; m_ok = 0; end
            end
        end else begin
            m_bad = (m_bad < 255) ? m_bad + 1 : 255;
            if (m_state == 2) m_ok = 0;
        end
        chk_model(full);
    endtask

    initial begin
        int bads = 0;
        model_reset();
        #12 chk_reset();
        @(negedge clk) rst_n = 1'b1;

        frame(MSG, 208'h1234, 1);
        frame(32'hDEADBEEF, 208'hBAD, 1);

        frame(MSG, rnd_pl(), 1);
        repeat (100) @(posedge clk);
        #1 chk("pre_timeout_state", 256'(state), 256'(1));
        @(posedge clk);
        #1 m_state = 2; m_ok = 0;
        chk_model(1);
        frame(MSG, rnd_pl(), 1);
        frame(rnd_bad(), rnd_pl(), 1);
        frame(MSG, rnd_pl(), 1);
        frame(MSG, rnd_pl(), 1);

        @(negedge clk) estop_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("estop_edge3_state", 256'(state), 256'(1));
        chk("estop_edge3_hdr", 256'(header_tx), 256'(DATA));
        @(posedge clk);
        #1 m_state = 2; m_ok = 0; m_estop = 1;
        chk_model(1);
        chk("estop_hdr", 256'(header_tx), 256'(ESTP));
        frame(MSG, rnd_pl(), 1);
        frame(MSG, rnd_pl(), 1);
        @(negedge clk) estop_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("estop_rel_edge3_hdr", 256'(header_tx), 256'(ESTP));
        @(posedge clk);
        #1 chk("estop_rel_hdr", 256'(header_tx), 256'(DATA));
        m_estop = 0;
        frame(MSG, rnd_pl(), 1);
        frame(MSG, rnd_pl(), 1);

        frame(MSG, rnd_pl(), 1);
        repeat (97) @(posedge clk);
        frame(MSG, rnd_pl(), 1);
        repeat (99) @(posedge clk);
        #1 chk("cnt_cleared_state", 256'(state), 256'(1));
        repeat (2) @(posedge clk);
        #1 m_state = 2; m_ok = 0;
        chk_model(1);

        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 8)) @(posedge clk);
            if (bads == 3 || $urandom_range(0, 1) == 1) begin
                frame(MSG, rnd_pl(), 1);
                bads = 0;
            end else begin
                frame(rnd_bad(), rnd_pl(), 1);
                bads++;
            end
        end
        for (int i = 0; i < 3 && m_state != 1; i++) frame(MSG, rnd_pl(), 1);

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 model_reset();
        chk_reset();
        @(negedge clk) rst_n = 1'b1;
        frame(MSG, 208'h55, 1);

        for (int i = 0; i < 300; i++) frame(rnd_bad(), rnd_pl(), 0);

        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFE;
        #1 release dut.frame_cnt_q;
        m_frames = 65534;
        frame(MSG, rnd_pl(), 0);
        frame(MSG, rnd_pl(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
